fetch_stage: RTL and testbench
==============================

// Module: fetch_stage
// PURPOSE
//  IF stage of the 16-bit RISC pipeline. Holds the PC and issues single-outstanding requests to an instruction memory
//  with variable latency (>=1 cycle). Delivers each instruction, its PC and PC+2 to the IF/ID pipeline registers, and
//  drives their write-enable and flush controls.
//  Handles hazard-unit stalls, branch redirects from EX, and the HLT opcode.
// PARAMETERS
//  PC_WIDTH     16     PC / imem address width (byte address, instructions 2-byte aligned)
//  INSTR_WIDTH  16     instruction width
//  RESET_PC     16'h0  PC loaded on reset
//  HALT_OPCODE  4'hF   value of instr[15:12] that halts fetch
// PORTS
//  clk            in   1            clock, all state on posedge
//  rst_n          in   1            asynchronous, active-low reset
//  stall          in   1            hazard unit: IF/ID must hold this cycle
//  branch_taken   in   1            EX resolved taken branch/jump this cycle
//  branch_target  in   PC_WIDTH     redirect address (bit0 ignored, forced 0)
//  imem_req       out  1            request strobe, one cycle per request
//  imem_addr      out  PC_WIDTH     request address (= pc while imem_req=1, else holds)
//  imem_valid     in   1            response strobe, one cycle per request
//  imem_rdata     in   INSTR_WIDTH  response data, valid with imem_valid
//  instr          out  INSTR_WIDTH  instruction presented to IF/ID
//  instr_pc       out  PC_WIDTH     PC of instr
//  pc_plus2       out  PC_WIDTH     instr_pc+2, mod 2^PC_WIDTH
//  ifid_wen       out  1            IF/ID write-enable (pulse per delivered instr)
//  ifid_flush     out  1            IF/ID flush (synchronous clear at IF/ID)
//  halted         out  1            fetch stopped on HLT
// BEHAVIOUR
//  Reset (rst_n=0, async): pc=RESET_PC, state=IDLE, buffer=0.
//  All outputs are 0 during reset, except imem_addr=RESET_PC.
//  States: IDLE, REQ, WAIT, HOLD, DRAIN, HALT.
//  IDLE  -> REQ next cycle. No other action.
//  REQ   -> imem_req=1, imem_addr=pc; always -> WAIT.
//  WAIT  -> waits for imem_valid.
//    On imem_valid with stall=0:
//      - ifid_wen=1 same cycle; instr=imem_rdata, instr_pc=pc.
//      - pc<=pc+2.
//      - Next state: HALT if imem_rdata[15:12]==HALT_OPCODE, else REQ.
//    On imem_valid with stall=1: latch rdata into buffer -> HOLD.
//  HOLD  -> instr=buffer; ifid_wen=0 while stall=1.
//    When stall=0: ifid_wen=1, pc<=pc+2, next HALT/REQ by the same opcode rule.
//  HALT  -> halted=1, no requests, ifid_wen=0; stays until branch_taken.
//  Branch (highest priority, any state except IDLE):
//    - ifid_flush=1, ifid_wen=0 that cycle; pc<=branch_target&~1.
//    - State in REQ or WAIT without imem_valid (request in flight) -> DRAIN.
//    - Otherwise (WAIT with imem_valid, HOLD, HALT) -> REQ; that response/buffer is discarded.
//    - branch_taken with stall=1: branch wins, flush asserted.
//  DRAIN -> imem_req=0; discard the next imem_valid, then -> REQ.
//    branch_taken again in DRAIN: flush, update pc, stay DRAIN.
//  PC wraps: 16'hFFFE+2 = 16'h0000; pc_plus2 is computed the same way.
//  At most one request outstanding; imem_valid outside WAIT/DRAIN is ignored.
//  instr/instr_pc/pc_plus2 are meaningful only when ifid_wen=1.
//  Async reset mid-request abandons it. A stale imem_valid arriving in IDLE/REQ after reset is ignored.
// TESTING
//  1. Reset, 1-cycle mem returning 16'h1234 at each addr -> requests at 0,2,4...
//     ifid_wen pulses every 2 cycles; pc_plus2 = 2,4,6.
//  2. 3-cycle latency, stall=1 during response -> HOLD; instr=buffer held.
//     Deliver exactly once when stall drops; no extra imem_req.
//  3. branch_taken (target 16'h0041) while WAIT in flight -> ifid_flush=1, DRAIN.
//     Stale rdata is dropped; next imem_addr=16'h0040.
//  4. Fetch 16'hF000 at pc=8 -> delivered, halted=1, no imem_req.
//     branch_taken target 16'h0010 -> flush, halted=0, request at 16'h0010.
//  5. RESET_PC=16'hFFFE -> first pc_plus2=16'h0000; second request addr=16'h0000.
//  6. Deassert rst_n mid-WAIT, send a late imem_valid -> outputs 0, ignored.
//     Fetch restarts at RESET_PC.

Source files
------------

// File: rtl/fetch_stage.sv
// fetch_stage: IF stage holding the PC, issuing single-outstanding imem requests and driving IF/ID controls.
module fetch_stage #(
  parameter int PC_WIDTH = 16,
  parameter int INSTR_WIDTH = 16,
  parameter logic [PC_WIDTH-1:0] RESET_PC = '0,
  parameter logic [3:0] HALT_OPCODE = 4'hF
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  output logic                   imem_req,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic                   imem_valid,
  input  logic [INSTR_WIDTH-1:0] imem_rdata,
  output logic [INSTR_WIDTH-1:0] instr,
  output logic [PC_WIDTH-1:0]    instr_pc,
  output logic [PC_WIDTH-1:0]    pc_plus2,
  output logic                   ifid_wen,
  output logic                   ifid_flush,
  output logic                   halted
);
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, DRAIN, HALT} state_t;
  state_t state_q, state_d;
  logic [PC_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d;
  logic [INSTR_WIDTH-1:0] buf_q, buf_d, cur;
  logic have, br, in_flight;
  always_comb begin
    have = (state_q == WAIT && imem_valid) || state_q == HOLD;
    br = branch_taken && state_q != IDLE;
    // a request is still outstanding unless this cycle's response consumes it
    in_flight = state_q == REQ || ((state_q == WAIT || state_q == DRAIN) && !imem_valid);
    cur = state_q == HOLD ? buf_q : imem_rdata;
    imem_req = state_q == REQ;
    imem_addr = imem_req ? pc_q : addr_q;
    addr_d = imem_addr;
    instr = have ? cur : '0;
    instr_pc = have ? pc_q : '0;
    pc_plus2 = have ? pc_q + PC_WIDTH'(2) : '0;
    halted = state_q == HALT;
    ifid_wen = have && !stall && !br;
    ifid_flush = br;
    buf_d = (state_q == WAIT && imem_valid && stall) ? imem_rdata : buf_q;
    state_d = state_q == IDLE ? REQ :
              state_q == REQ ? WAIT :
              (state_q == DRAIN && imem_valid) ? REQ :
              (state_q == WAIT && imem_valid && stall) ? HOLD : state_q;
    pc_d = pc_q;
    if (ifid_wen) begin
      pc_d = pc_q + PC_WIDTH'(2);
      state_d = cur[INSTR_WIDTH-1 -: 4] == HALT_OPCODE ? HALT : REQ;
    end
    if (br) begin
      pc_d = {branch_target[PC_WIDTH-1:1], 1'b0};
      state_d = in_flight ? DRAIN : REQ;
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      addr_q <= RESET_PC;
      buf_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      addr_q <= addr_d;
      buf_q <= buf_d;
    end
  end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed cycle-by-cycle vectors for fetch_stage, plus reset-wrap and async-reset sequences.
module tb_fetch_stage;
  logic clk = 0, rst_n = 0, stall = 0, branch_taken = 0;
  logic [15:0] branch_target = 0;
  logic imem_req, ifid_wen, ifid_flush, halted, imem_valid = 0;
  logic [15:0] imem_addr, imem_rdata = 0, instr, instr_pc, pc_plus2;
  logic w_req, w_wen, w_flush, w_halted, w_valid = 0;
  logic [15:0] w_addr, w_rdata = 0, w_instr, w_ipc, w_p2;
  int cmp = 0, err = 0;

  always #5 clk = ~clk;

  fetch_stage dut (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_valid(imem_valid), .imem_rdata(imem_rdata),
    .instr(instr), .instr_pc(instr_pc), .pc_plus2(pc_plus2), .ifid_wen(ifid_wen),
    .ifid_flush(ifid_flush), .halted(halted)
  );

  fetch_stage #(.RESET_PC(16'hFFFE)) dut_w (
    .clk(clk), .rst_n(rst_n), .stall(stall), .branch_taken(branch_taken), .branch_target(branch_target),
    .imem_req(w_req), .imem_addr(w_addr), .imem_valid(w_valid), .imem_rdata(w_rdata),
    .instr(w_instr), .instr_pc(w_ipc), .pc_plus2(w_p2), .ifid_wen(w_wen),
    .ifid_flush(w_flush), .halted(w_halted)
  );

  typedef struct {
    logic st, br; logic [15:0] tgt; logic vld; logic [15:0] rd;
    logic req; logic [15:0] addr; logic wen, fl, hlt, ci; logic [15:0] ins, ipc, p2;
  } vec_t;
  vec_t tbl[$];
  vec_t rst_tbl[$];

  task automatic chk(input string n, input logic [15:0] a, input logic [15:0] e);
    cmp++;
    if (a !== e) begin
      err++;
      $display("FAIL %s got %h want %h", n, a, e);
    end
  endtask

  // drive at negedge, check 2ns later, return at next negedge
  task automatic cyc(input string tag, input int i, input vec_t v);
    string n;
    n = $sformatf("%s[%0d]", tag, i);
    stall = v.st; branch_taken = v.br; branch_target = v.tgt; imem_valid = v.vld; imem_rdata = v.rd;
    #2;
    chk({n, " req"}, 16'(imem_req), 16'(v.req));
    chk({n, " addr"}, imem_addr, v.addr);
    chk({n, " wen"}, 16'(ifid_wen), 16'(v.wen));
    chk({n, " flush"}, 16'(ifid_flush), 16'(v.fl));
    chk({n, " halted"}, 16'(halted), 16'(v.hlt));
    if (v.wen || v.ci) chk({n, " instr"}, instr, v.ins);
    if (v.wen) begin
      chk({n, " instr_pc"}, instr_pc, v.ipc);
      chk({n, " pc_plus2"}, pc_plus2, v.p2);
    end
    @(negedge clk);
  endtask

  initial begin
    //          st br tgt      vld rd        req addr     wen fl hlt ci ins       ipc       p2
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0000, 1, 0, 0, 0, 16'h1234, 16'h0000, 16'h0002});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0002, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0002, 1, 0, 0, 0, 16'h1234, 16'h0002, 16'h0004});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0004, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'h1234, 0, 16'h0004, 1, 0, 0, 0, 16'h1234, 16'h0004, 16'h0006});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0006, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0006, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0006, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 1, 16'h2AB0, 0, 16'h0006, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{1, 0, 16'h0000, 0, 16'h0000, 0, 16'h0006, 0, 0, 0, 1, 16'h2AB0, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0006, 1, 0, 0, 0, 16'h2AB0, 16'h0006, 16'h0008});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0008, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'hF000, 0, 16'h0008, 1, 0, 0, 0, 16'hF000, 16'h0008, 16'h000A});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0008, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'h7777, 0, 16'h0008, 0, 0, 1, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1, 16'h0010, 0, 16'h0000, 0, 16'h0008, 0, 1, 1, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0010, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 1, 16'h0041, 0, 16'h0000, 0, 16'h0010, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0010, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'hDEAD, 0, 16'h0010, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0040, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'h5555, 0, 16'h0040, 1, 0, 0, 0, 16'h5555, 16'h0040, 16'h0042});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0042, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{1, 1, 16'h0100, 1, 16'h6666, 0, 16'h0042, 0, 1, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0100, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 1, 16'h0777, 0, 16'h0100, 1, 0, 0, 0, 16'h0777, 16'h0100, 16'h0102});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 1, 16'h0102, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    tbl.push_back('{0, 0, 16'h0000, 0, 16'h0000, 0, 16'h0102, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    // after async reset: stale valid in IDLE and REQ is ignored, then a fresh fetch at RESET_PC
    rst_tbl.push_back('{0, 0, 16'h0000, 1, 16'h1111, 0, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    rst_tbl.push_back('{0, 0, 16'h0000, 1, 16'h1111, 1, 16'h0000, 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000});
    rst_tbl.push_back('{0, 0, 16'h0000, 1, 16'h4321, 0, 16'h0000, 1, 0, 0, 0, 16'h4321, 16'h0000, 16'h0002});

    repeat (2) @(negedge clk);
    #2;
    chk("reset req", 16'(imem_req), 16'h0);
    chk("reset addr", imem_addr, 16'h0000);
    chk("reset wen", 16'(ifid_wen), 16'h0);
    chk("reset flush", 16'(ifid_flush), 16'h0);
    chk("reset halted", 16'(halted), 16'h0);
    chk("reset w addr", w_addr, 16'hFFFE);
    @(negedge clk);
    rst_n = 1;
    foreach (tbl[i]) cyc("main", i, tbl[i]);

    // async reset while WAIT has a request outstanding
    #2;
    rst_n = 0; imem_valid = 1; imem_rdata = 16'h1111;
    #1;
    chk("async req", 16'(imem_req), 16'h0);
    chk("async addr", imem_addr, 16'h0000);
    chk("async wen", 16'(ifid_wen), 16'h0);
    chk("async instr", instr, 16'h0000);
    chk("async instr_pc", instr_pc, 16'h0000);
    chk("async pc_plus2", pc_plus2, 16'h0000);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1;
    foreach (rst_tbl[i]) cyc("rst", i, rst_tbl[i]);

    // PC wrap from RESET_PC = FFFE
    rst_n = 0; imem_valid = 0; stall = 0; branch_taken = 0; w_valid = 0;
    @(negedge clk);
    rst_n = 1;
    #2 chk("wrap idle req", 16'(w_req), 16'h0);
    @(negedge clk);
    #2 chk("wrap req", 16'(w_req), 16'h1);
    chk("wrap addr0", w_addr, 16'hFFFE);
    @(negedge clk);
    w_valid = 1; w_rdata = 16'h1234;
    #2 chk("wrap wen", 16'(w_wen), 16'h1);
    chk("wrap instr_pc", w_ipc, 16'hFFFE);
    chk("wrap pc_plus2", w_p2, 16'h0000);
    @(negedge clk);
    w_valid = 0;
    #2 chk("wrap req2", 16'(w_req), 16'h1);
    chk("wrap addr1", w_addr, 16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, err);
    $finish;
  end
endmodule
